// File: rtl/mem_store_buffer_if.sv
// -----------------------------------------------------------------------------
// mem_store_buffer_if
// Bus bundle between the MEM-stage store/load path, the store buffer and the
// data-memory write port.
//   Store request : st_valid, st_type, st_addr, st_data, st_pc -> st_ready, st_misalign
//   Load check    : ld_valid, ld_addr                          -> ld_stall
//   DM write port : dm_hold -> memw_enable, byteen, mem_adr, mem_write, MPC
// Modports:
//   master : pipeline / DM side (drives requests and dm_hold)
//   slave  : the store buffer
// -----------------------------------------------------------------------------
interface mem_store_buffer_if;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        st_misalign;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;

    logic        dm_hold;
    logic        memw_enable;
    logic [3:0]  byteen;
    logic [31:0] mem_adr;
    logic [31:0] mem_write;
    logic [31:0] MPC;

    modport master (
        output st_valid, st_type, st_addr, st_data, st_pc,
        output ld_valid, ld_addr, dm_hold,
        input  st_ready, st_misalign, ld_stall,
        input  memw_enable, byteen, mem_adr, mem_write, MPC
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, st_pc,
        input  ld_valid, ld_addr, dm_hold,
        output st_ready, st_misalign, ld_stall,
        output memw_enable, byteen, mem_adr, mem_write, MPC
    );
endinterface

// File: rtl/mem_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer
// Posted-write queue between the MEM-stage store path and the data memory.
// Accepts sw/sh/sb, derives the byte enable from the low address bits, queues
// up to DEPTH stores and drains one per cycle into the DM write port. Loads
// whose word address matches any pending store are stalled.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; empties the queue
//   bus    : mem_store_buffer_if.slave (store request, load check, DM port)
//
// Parameters:
//   DEPTH  : queue entries, power of two, >= 2
//   PTR_W  : log2(DEPTH)
//
// Optional feature (macro STORE_TRACE_EN):
//   defined   -> each entry keeps the store PC, MPC shows the head PC and every
//                committed write is printed at the popping edge.
//   undefined -> no PC storage, MPC tied to 0.
// -----------------------------------------------------------------------------
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic               clk,
    input logic               reset,
    mem_store_buffer_if.slave bus
);
    logic [29:0]      waddr_q [DEPTH];
    logic [3:0]       be_q    [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic       bad_align;
    logic [3:0] st_be;
    logic       ld_hit;

    // Byte-enable derivation and alignment check for the incoming store.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        st_be     = 4'b0000;
        bad_align = 1'b0;
        case (bus.st_type)
            2'b00: begin
                st_be     = 4'b1111;
                bad_align = (bus.st_addr[1:0] != 2'b00);
            end
            2'b01: begin
                st_be     = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                bad_align = bus.st_addr[0];
            end
            2'b10: st_be = 4'b0001 << bus.st_addr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

    // A full queue refuses the push even when a pop happens this cycle.
    assign push = bus.st_valid & ~full & ~bad_align;
    assign pop  = ~empty & ~bus.dm_hold;

    assign bus.st_ready    = ~full;
    assign bus.st_misalign = bus.st_valid & bad_align;

    // Control state. Pointers are PTR_W bits wide and wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            // Push and pop never target the same slot: a pop needs a non-empty
            // queue and a push needs a non-full one, so head != tail when both fire.
            if (pop) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            if (push) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: the payload array is deliberately left out of reset; the valid bits
    // and count gate every consumer, so stale payload is never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_q[tail_q] <= bus.st_addr[31:2];
            be_q[tail_q]    <= st_be;
            data_q[tail_q]  <= bus.st_data;
        end
    end

    // Word-granular hazard check against every pending entry; byte overlap is
    // not considered.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == bus.ld_addr[31:2])) ld_hit = 1'b1;
        end
    end

    assign bus.ld_stall = bus.ld_valid & ld_hit;

    // DM port is driven straight from the head entry; zeros when empty.
    assign bus.memw_enable = pop;
    assign bus.byteen      = empty ? 4'b0000 : be_q[head_q];
    assign bus.mem_adr     = empty ? 32'h0 : {waddr_q[head_q], 2'b00};
    assign bus.mem_write   = empty ? 32'h0 : data_q[head_q];

`ifdef STORE_TRACE_EN
    logic [31:0] pc_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) pc_q[tail_q] <= bus.st_pc;
    end

    assign bus.MPC = empty ? 32'h0 : pc_q[head_q];

    always_ff @(posedge clk) begin
        if (!reset && pop) $display("@%h: *%h <= %h", bus.MPC, bus.mem_adr, bus.mem_write);
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.st_pc;
    assign bus.MPC   = 32'h0;
`endif
endmodule
